cc_gravity: RTL and testbench

- Post-clear gravity stage for the 6x6 candy board. It sits directly downstream of the match-scan/clear stage.
- It consumes the board after matched cells have been overwritten with the empty code. It compacts every column downward so that all candies rest at the bottom and all empties collect at the top.
- It returns the settled board, an empty-cell count for the refill stage, and a moved flag so the controller knows whether another scan pass is needed.

---
 rtl/cc_pkg.sv | 38 +++
 rtl/cc_gravity_col.sv | 38 +++
 rtl/cc_gravity.sv | 131 +++++++++++++
 tb/tb_cc_gravity.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared constants, cell indexing and FSM states for the candy board
package cc_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 6;
  localparam int CW      = 3;
  localparam int BOARD_W = ROWS * COLS * CW;
  localparam int COL_W   = ROWS * CW;
  localparam logic [2:0] MAX_STEPS = 3'd5;

  localparam logic [CW-1:0] RED    = 3'd0;
  localparam logic [CW-1:0] ORANGE = 3'd1;
  localparam logic [CW-1:0] YELLOW = 3'd2;
  localparam logic [CW-1:0] GREEN  = 3'd3;
  localparam logic [CW-1:0] BLUE   = 3'd4;
  localparam logic [CW-1:0] PURPLE = 3'd5;
  localparam logic [CW-1:0] EMPTY  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_e;

  function automatic int cell_idx(input int r, input int c);
    return r * COLS + c;
  endfunction

  function automatic logic [5:0] count_empty(input logic [BOARD_W-1:0] b);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (b[i*CW +: CW] == EMPTY) n = n + 6'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/cc_gravity_col.sv
// rtl/cc_gravity_col.sv - one settle step for a single column (row 0 = top)
module cc_gravity_col
  import cc_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o,
  output logic             movable_o
);

  logic [ROWS-1:0] cand;
  logic [ROWS-1:0] shift;
  logic            above;
  logic            acc;

  always_comb begin
    cand  = '0;
    shift = '0;
    above = 1'b0;
    acc   = 1'b0;
    // A hole is a candidate only if some candy sits above it.
    for (int r = 0; r < ROWS; r++) begin
      cand[r] = (col_i[r*CW +: CW] == EMPTY) && above;
      above   = above | (col_i[r*CW +: CW] != EMPTY);
    end
    // Every row at or above the lowest candidate moves down by one.
    for (int r = ROWS - 1; r >= 0; r--) begin
      acc      = acc | cand[r];
      shift[r] = acc;
    end
    col_o = col_i;
    if (shift[0]) col_o[0 +: CW] = EMPTY;
    for (int r = 1; r < ROWS; r++) begin
      if (shift[r]) col_o[r*CW +: CW] = col_i[(r-1)*CW +: CW];
    end
    movable_o = |cand;
  end

endmodule

// File: rtl/cc_gravity.sv
// rtl/cc_gravity.sv - post-clear gravity stage: settles every column of the 6x6 board
module cc_gravity
  import cc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BOARD_W-1:0] in_board,
  output logic               busy,
  output logic               out_valid,
  output logic [BOARD_W-1:0] out_board,
  output logic [5:0]         out_empty_cnt,
  output logic               out_moved,
  output logic [2:0]         out_steps
);

  state_e             state_q;
  logic [BOARD_W-1:0] board_q;
  logic [BOARD_W-1:0] board_d;
  logic [2:0]         steps_q;
  logic               moved_q;
  logic               busy_q;
  logic               out_valid_q;
  logic [BOARD_W-1:0] out_board_q;
  logic [5:0]         out_empty_q;
  logic               out_moved_q;
  logic [2:0]         out_steps_q;

  logic [COL_W-1:0]   col_in  [COLS];
  logic [COL_W-1:0]   col_out [COLS];
  logic [COLS-1:0]    col_mov;
  logic               any_mov;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      col_in[c] = '0;
      for (int r = 0; r < ROWS; r++) begin
        col_in[c][r*CW +: CW] = board_q[cell_idx(r, c)*CW +: CW];
      end
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_col
    cc_gravity_col u_col (
      .col_i    (col_in[gc]),
      .col_o    (col_out[gc]),
      .movable_o(col_mov[gc])
    );
  end

  always_comb begin
    board_d = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        board_d[cell_idx(r, c)*CW +: CW] = col_out[c][r*CW +: CW];
      end
    end
  end

  assign any_mov = |col_mov;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      board_q     <= '0;
      steps_q     <= '0;
      moved_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_board_q <= '0;
      out_empty_q <= '0;
      out_moved_q <= 1'b0;
      out_steps_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_q <= 1'b0;
          if (start) begin
            board_q <= in_board;
            steps_q <= '0;
            moved_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (any_mov && steps_q == MAX_STEPS) begin
            // Safety net: never settle past the step budget.
            board_q     <= board_d;
            moved_q     <= 1'b1;
            out_board_q <= board_d;
            out_empty_q <= count_empty(board_d);
            out_moved_q <= 1'b1;
            out_steps_q <= MAX_STEPS;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (any_mov) begin
            board_q <= board_d;
            steps_q <= steps_q + 3'd1;
            moved_q <= 1'b1;
          end else begin
            out_board_q <= board_q;
            out_empty_q <= count_empty(board_q);
            out_moved_q <= moved_q;
            out_steps_q <= steps_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign out_valid     = out_valid_q;
  assign out_board     = out_board_q;
  assign out_empty_cnt = out_empty_q;
  assign out_moved     = out_moved_q;
  assign out_steps     = out_steps_q;

endmodule

// File: tb/tb_cc_gravity.sv
// tb/tb_cc_gravity.sv - directed self-checking bench for cc_gravity
module tb_cc_gravity;
  import cc_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [107:0] in_board;
  logic         busy;
  logic         out_valid;
  logic [107:0] out_board;
  logic [5:0]   out_empty_cnt;
  logic         out_moved;
  logic [2:0]   out_steps;

  int checks = 0;
  int errors = 0;

  cc_gravity dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_board     (in_board),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_board    (out_board),
    .out_empty_cnt(out_empty_cnt),
    .out_moved    (out_moved),
    .out_steps    (out_steps)
  );

  always #5 clk = ~clk;

  function automatic logic [107:0] put(input logic [107:0] b, input int r, input int c,
                                       input logic [2:0] v);
    b[(6*r+c)*3 +: 3] = v;
    return b;
  endfunction

  function automatic logic [107:0] set_col(input logic [107:0] b, input int c,
                                           input logic [2:0] v0, input logic [2:0] v1,
                                           input logic [2:0] v2, input logic [2:0] v3,
                                           input logic [2:0] v4, input logic [2:0] v5);
    b = put(b, 0, c, v0); b = put(b, 1, c, v1); b = put(b, 2, c, v2);
    b = put(b, 3, c, v3); b = put(b, 4, c, v4); b = put(b, 5, c, v5);
    return b;
  endfunction

  // Colours 0..6 (including the unused 110 code); never EMPTY.
  function automatic logic [107:0] base_board();
    logic [107:0] b;
    b = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) b = put(b, r, c, 3'((r + c) % 7));
    return b;
  endfunction

  function automatic logic [107:0] all_empty();
    logic [107:0] b;
    b = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) b = put(b, r, c, EMPTY);
    return b;
  endfunction

  // Issue start, then count edges after the accepting edge until out_valid is seen.
  task automatic run_op(input logic [107:0] b, output int lat, output logic busy_after);
    @(negedge clk);
    in_board = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    busy_after = busy;
    lat        = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_board = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    checks++;
    if (out_board !== 108'd0 || out_empty_cnt !== 6'd0 || out_moved !== 1'b0 || out_steps !== 3'd0) begin
      errors++; $display("FAIL reset_outs board=%h cnt=%0d moved=%b steps=%0d want all 0",
                         out_board, out_empty_cnt, out_moved, out_steps);
    end
  endtask

  task automatic test_full_board();
    int lat; logic b_after; logic [107:0] b;
    b = base_board();
    run_op(b, lat, b_after);
    checks++;
    if (b_after !== 1'b1) begin errors++; $display("FAIL full_busy got %b want 1", b_after); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL full_latency got %0d want 1", lat); end
    checks++;
    if (out_board !== b) begin errors++; $display("FAIL full_board got %h want %h", out_board, b); end
    checks++;
    if (out_steps !== 3'd0 || out_moved !== 1'b0 || out_empty_cnt !== 6'd0) begin
      errors++; $display("FAIL full_stats steps=%0d moved=%b cnt=%0d want 0 0 0",
                         out_steps, out_moved, out_empty_cnt);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_valid got %b want 1", busy); end
  endtask

  task automatic test_single_hole();
    int lat; logic b_after; logic [107:0] b, exp;
    b   = set_col(base_board(), 0, RED, BLUE, GREEN, YELLOW, ORANGE, EMPTY);
    exp = set_col(base_board(), 0, EMPTY, RED, BLUE, GREEN, YELLOW, ORANGE);
    run_op(b, lat, b_after);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL hole_latency got %0d want 2", lat); end
    checks++;
    if (out_board !== exp) begin errors++; $display("FAIL hole_board got %h want %h", out_board, exp); end
    checks++;
    if (out_steps !== 3'd1 || out_moved !== 1'b1 || out_empty_cnt !== 6'd1) begin
      errors++; $display("FAIL hole_stats steps=%0d moved=%b cnt=%0d want 1 1 1",
                         out_steps, out_moved, out_empty_cnt);
    end
  endtask

  task automatic test_alternating();
    int lat; logic b_after; logic [107:0] b, exp;
    b   = set_col(base_board(), 2, GREEN, EMPTY, GREEN, EMPTY, GREEN, EMPTY);
    exp = set_col(base_board(), 2, EMPTY, EMPTY, EMPTY, GREEN, GREEN, GREEN);
    run_op(b, lat, b_after);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL alt_latency got %0d want 4", lat); end
    checks++;
    if (out_board !== exp) begin errors++; $display("FAIL alt_board got %h want %h", out_board, exp); end
    checks++;
    if (out_steps !== 3'd3 || out_moved !== 1'b1 || out_empty_cnt !== 6'd3) begin
      errors++; $display("FAIL alt_stats steps=%0d moved=%b cnt=%0d want 3 1 3",
                         out_steps, out_moved, out_empty_cnt);
    end
  endtask

  task automatic test_worst_case();
    int lat; logic b_after; logic [107:0] b, exp;
    b   = put(all_empty(), 0, 4, PURPLE);
    exp = put(all_empty(), 5, 4, PURPLE);
    run_op(b, lat, b_after);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL worst_latency got %0d want 6", lat); end
    checks++;
    if (out_board !== exp) begin errors++; $display("FAIL worst_board got %h want %h", out_board, exp); end
    checks++;
    if (out_steps !== 3'd5 || out_moved !== 1'b1 || out_empty_cnt !== 6'd35) begin
      errors++; $display("FAIL worst_stats steps=%0d moved=%b cnt=%0d want 5 1 35",
                         out_steps, out_moved, out_empty_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int lat; int extra_valid; logic busy_ok; logic [107:0] a, b, exp;
    a   = set_col(base_board(), 2, GREEN, EMPTY, GREEN, EMPTY, GREEN, EMPTY);
    exp = set_col(base_board(), 2, EMPTY, EMPTY, EMPTY, GREEN, GREEN, GREEN);
    b   = set_col(base_board(), 0, RED, BLUE, GREEN, YELLOW, ORANGE, EMPTY);
    @(negedge clk);
    in_board = a; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; busy_ok = busy;
    @(posedge clk);
    @(negedge clk);
    busy_ok = busy_ok & busy;
    in_board = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_board = '0;
    lat = 2;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL ign_latency got %0d want 4", lat); end
    checks++;
    if (busy_ok !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL ign_busy got ok=%b busy=%b want 1 1", busy_ok, busy);
    end
    checks++;
    if (out_board !== exp || out_steps !== 3'd3) begin
      errors++; $display("FAIL ign_result board=%h steps=%0d want %h 3", out_board, out_steps, exp);
    end
    extra_valid = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) extra_valid++;
    end
    checks++;
    if (extra_valid !== 0) begin errors++; $display("FAIL ign_no_queue got %0d active cycles want 0", extra_valid); end
    checks++;
    if (out_board !== exp) begin errors++; $display("FAIL ign_hold got %h want %h", out_board, exp); end
  endtask

  task automatic test_abort();
    int lat; int seen; logic b_after; logic [107:0] w, full;
    w    = put(all_empty(), 0, 4, PURPLE);
    full = base_board();
    @(negedge clk);
    in_board = w; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    checks++;
    if (out_board !== 108'd0 || out_steps !== 3'd0 || out_empty_cnt !== 6'd0) begin
      errors++; $display("FAIL abort_outs board=%h steps=%0d cnt=%0d want 0 0 0",
                         out_board, out_steps, out_empty_cnt);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got %0d pulses want 0", seen); end
    run_op(full, lat, b_after);
    checks++;
    if (lat !== 1 || out_board !== full || out_moved !== 1'b0) begin
      errors++; $display("FAIL abort_restart lat=%0d moved=%b board=%h want 1 0 %h",
                         lat, out_moved, out_board, full);
    end
  endtask

  initial begin
    test_reset();
    test_full_board();
    test_single_hole();
    test_alternating();
    test_worst_case();
    test_start_ignored();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
